// File: rtl/io_spi_master_if.sv
// IO-page bus bundle between the FemtoRV32 core and the SPI master.
// Strobes arrive pre-qualified; selects are the decoded one-hot address bits.
interface io_spi_master_if;
   logic        io_rstrb;
   logic        io_wstrb;
   logic        sel_data;
   logic        sel_ctrl;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (
      output io_rstrb, io_wstrb, sel_data, sel_ctrl, wdata,
      input  rdata
   );

   modport slave (
      input  io_rstrb, io_wstrb, sel_data, sel_ctrl, wdata,
      output rdata
   );
endinterface

// File: rtl/io_spi_master.sv
// SPI master, mode 0, MSB first, 8-bit frames, on the FemtoRV32 IO page.
// CTRL holds divider and chip select; writing DATA starts a byte.
module io_spi_master #(
   parameter int DIV_WIDTH   = 8,
   parameter int DEFAULT_DIV = 14
) (
   input  logic            clk,
   input  logic            reset,
   io_spi_master_if.slave  bus,
   output logic            sclk,
   output logic            mosi,
   input  logic            miso,
   output logic            cs_n
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOW,
      S_HIGH
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [DIV_WIDTH-1:0] r_div;
   logic [DIV_WIDTH-1:0] r_cnt;
   logic [DIV_WIDTH-1:0] w_start_div;
   logic                 r_cs;
   logic                 r_done;
   logic [7:0]           r_tx;
   logic [7:0]           r_sh;
   logic [7:0]           r_rx;
   logic [2:0]           r_bit;
   logic                 w_busy;
   logic                 w_wr_ctrl;
   logic                 w_wr_data;
   logic                 w_rd_data;
   logic                 w_phase_end;
   logic                 w_finish;
   logic [31:0]          w_rview;
   logic                 w_unused;

   assign w_unused = &{1'b0, bus.wdata[31:9]};

   assign w_busy      = (r_state != S_IDLE);
   assign w_wr_ctrl   = bus.io_wstrb & bus.sel_ctrl & ~w_busy;
   assign w_wr_data   = bus.io_wstrb & bus.sel_data & ~w_busy;
   assign w_rd_data   = bus.io_rstrb & bus.sel_data;
   assign w_phase_end = (r_cnt == '0);
   assign w_finish    = (r_state == S_HIGH) & w_phase_end & (r_bit == 3'd7);

   // A combined CTRL+DATA write starts with the freshly written divider
   assign w_start_div = w_wr_ctrl ? bus.wdata[DIV_WIDTH-1:0] : r_div;

   always_comb begin
      w_next = r_state;
      sclk   = 1'b0;
      mosi   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_wr_data)
               w_next = S_LOW;
         end
         S_LOW: begin
            mosi = r_tx[7];
            if (w_phase_end)
               w_next = S_HIGH;
         end
         S_HIGH: begin
            sclk = 1'b1;
            mosi = r_tx[7];
            if (w_phase_end)
               w_next = (r_bit == 3'd7) ? S_IDLE : S_LOW;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_rview = 32'd0;
      if (bus.sel_ctrl)
         w_rview = w_rview | {21'd0, r_done, w_busy, r_cs, 8'(r_div)};
      if (bus.sel_data)
         w_rview = w_rview | {24'd0, r_rx};
   end

   assign cs_n = ~r_cs;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_div     <= DIV_WIDTH'(DEFAULT_DIV);
         r_cnt     <= '0;
         r_cs      <= 1'b0;
         r_done    <= 1'b0;
         r_tx      <= 8'd0;
         r_sh      <= 8'd0;
         r_rx      <= 8'd0;
         r_bit     <= 3'd0;
         bus.rdata <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_wr_ctrl) begin
            r_div <= bus.wdata[DIV_WIDTH-1:0];
            r_cs  <= bus.wdata[8];
         end
         if (w_wr_data) begin
            r_tx  <= bus.wdata[7:0];
            r_cnt <= w_start_div;
            r_bit <= 3'd0;
         end else if (w_busy) begin
            r_cnt <= w_phase_end ? r_div : r_cnt - 1'b1;
            if (r_state == S_LOW && w_phase_end)
               r_sh <= {r_sh[6:0], miso};
            if (r_state == S_HIGH && w_phase_end) begin
               r_tx  <= {r_tx[6:0], 1'b0};
               r_bit <= r_bit + 3'd1;
            end
         end
         // Completion beats a same-cycle DATA read so the flag is not lost
         if (w_finish) begin
            r_done <= 1'b1;
            r_rx   <= r_sh;
         end else if (w_wr_data || w_rd_data) begin
            r_done <= 1'b0;
         end
         if (bus.io_rstrb)
            bus.rdata <= w_rview;
      end
   end

endmodule
